// File: rtl/seven_segment_decoder.sv
// Readback monitor for a 7-segment display bus: debounces the active-low segment
// pattern, decodes it to a hex digit + DP, and counts illegal patterns.
module seven_segment_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       seg_in,
    output logic [3:0]       out_value,
    output logic             out_dp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             seg_err,
    output logic [ERR_W-1:0] err_count,
    output logic             overrun,
    input  logic             clr,
    output logic             state_dbg
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       seg_q;
    logic             change;
    logic             fire;
    logic             legal;
    logic             blank;
    logic [3:0]       dec_value;
    logic             event_v;
    logic             err_v;
    logic             drop;

    // Out stream: out_valid/out_value/out_dp form a standard valid/ready pair;
    // an event transfers on a rising edge where out_valid & out_ready, and the
    // data is held unchanged while out_valid & !out_ready.
    logic [3:0]       value_q;
    logic             dp_q;
    logic             valid_q;
    logic             seg_err_q;
    logic [ERR_W-1:0] err_count_q;
    logic             overrun_q;

    assign change = (seg_in != seg_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seg_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (change) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (change) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fire = (state_q == SETTLE) && !change && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
    end

    always_comb begin
        legal     = 1'b1;
        dec_value = 4'h0;
        case (seg_q[6:0])
            7'b1000000: dec_value = 4'h0;
            7'b1111001: dec_value = 4'h1;
            7'b0100100: dec_value = 4'h2;
            7'b0110000: dec_value = 4'h3;
            7'b0011001: dec_value = 4'h4;
            7'b0010010: dec_value = 4'h5;
            7'b0000010: dec_value = 4'h6;
            7'b1111000: dec_value = 4'h7;
            7'b0000000: dec_value = 4'h8;
            7'b0011000: dec_value = 4'h9;
            7'b0001000: dec_value = 4'hA;
            7'b0000011: dec_value = 4'hB;
            7'b1000110: dec_value = 4'hC;
            7'b0100001: dec_value = 4'hD;
            7'b0000110: dec_value = 4'hE;
            7'b0001110: dec_value = 4'hF;
            default:    legal     = 1'b0;
        endcase
    end

    assign blank   = (seg_q[6:0] == 7'h7F);
    assign event_v = fire && legal;
    assign err_v   = fire && !legal && !blank;
    assign drop    = event_v && valid_q && !out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q     <= 4'h0;
            dp_q        <= 1'b0;
            valid_q     <= 1'b0;
            seg_err_q   <= 1'b0;
            err_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (event_v && (!valid_q || out_ready)) begin
                value_q <= dec_value;
                dp_q    <= ~seg_q[7];
                valid_q <= 1'b1;
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
            seg_err_q <= err_v;
            // clr takes priority over a same-cycle increment or drop
            if (clr) begin
                err_count_q <= '0;
                overrun_q   <= 1'b0;
            end else begin
                if (err_v && (err_count_q != {ERR_W{1'b1}})) begin
                    err_count_q <= err_count_q + 1'b1;
                end
                if (drop) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign out_value = value_q;
    assign out_dp    = dp_q;
    assign out_valid = valid_q;
    assign seg_err   = seg_err_q;
    assign err_count = err_count_q;
    assign overrun   = overrun_q;
    assign state_dbg = (state_q == SETTLE);

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder: timing, table sweep, glitch rejection,
// error counting/saturation, backpressure and asynchronous reset.
module tb_seven_segment_decoder;

    logic       clk;
    logic       reset_n;
    logic [7:0] seg_in;
    logic       out_ready;
    logic       clr;

    logic [3:0] out_value, out_value2;
    logic       out_dp, out_dp2;
    logic       out_valid, out_valid2;
    logic       seg_err, seg_err2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic       overrun, overrun2;
    logic       state_dbg, state_dbg2;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];
    logic [6:0] pat [16];
    logic [7:0] illegal [4];

    seven_segment_decoder #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .seg_in(seg_in),
        .out_value(out_value), .out_dp(out_dp), .out_valid(out_valid),
        .out_ready(out_ready), .seg_err(seg_err), .err_count(err_count),
        .overrun(overrun), .clr(clr), .state_dbg(state_dbg)
    );

    seven_segment_decoder #(.STABLE_CYCLES(4), .ERR_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .seg_in(seg_in),
        .out_value(out_value2), .out_dp(out_dp2), .out_valid(out_valid2),
        .out_ready(out_ready), .seg_err(seg_err2), .err_count(err_count2),
        .overrun(overrun2), .clr(clr), .state_dbg(state_dbg2)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [7:0] s, input int n);
        seg_in = s;
        step(n);
    endtask

    // scoreboard: every accepted transfer must match the head of exp_q
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("ev_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                check("ev_data", {27'd0, out_dp, out_value}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        pat[0]  = 7'h40; pat[1]  = 7'h79; pat[2]  = 7'h24; pat[3]  = 7'h30;
        pat[4]  = 7'h19; pat[5]  = 7'h12; pat[6]  = 7'h02; pat[7]  = 7'h78;
        pat[8]  = 7'h00; pat[9]  = 7'h18; pat[10] = 7'h08; pat[11] = 7'h03;
        pat[12] = 7'h46; pat[13] = 7'h21; pat[14] = 7'h06; pat[15] = 7'h0E;
        illegal[0] = 8'hFE; illegal[1] = 8'hBF; illegal[2] = 8'hF7; illegal[3] = 8'hFD;

        reset_n   = 1'b0;
        seg_in    = 8'hFF;
        out_ready = 1'b1;
        clr       = 1'b0;
        step(3);
        check("rst_valid", out_valid, 0);
        check("rst_value", out_value, 0);
        check("rst_err",   err_count, 0);
        check("rst_state", state_dbg, 0);
        reset_n = 1'b1;
        step(2);

        // 1: first-event latency, single event for a held pattern
        exp_q.push_back({1'b0, 4'h0});
        seg_in = 8'hC0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check($sformatf("t1_valid_%0d", i), out_valid, (i == 5) ? 1 : 0);
            if (i == 5) begin
                check("t1_value", out_value, 0);
                check("t1_dp", out_dp, 0);
            end
        end

        // 2: full table sweep, both DP states
        hold(8'hFF, 6);
        for (int v = 0; v < 16; v++) begin
            for (int d = 0; d < 2; d++) begin
                exp_q.push_back({d[0], v[3:0]});
                hold({~d[0], pat[v]}, 6);
            end
        end
        check("t2_err", err_count, 0);
        check("t2_drained", exp_q.size(), 0);

        // 3: short glitch of '1' is ignored
        exp_q.push_back({1'b0, 4'h2});
        hold(8'hF9, 2);
        hold(8'hA4, 8);
        check("t3_drained", exp_q.size(), 0);

        // 4: illegal patterns, seg_err pulse, saturation, clr
        hold(8'hFF, 6);
        seg_in = 8'hB6;
        step(4);
        check("t4_err_early", seg_err, 0);
        step(1);
        check("t4_err_pulse", seg_err, 1);
        check("t4_count1", err_count, 1);
        check("t4_noevent", out_valid, 0);
        step(1);
        check("t4_err_end", seg_err, 0);
        for (int k = 0; k < 4; k++) begin
            hold(8'hFF, 6);
            hold(illegal[k], 6);
        end
        check("t4_count5", err_count, 5);
        check("t4_sat", err_count2, 3);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("t4_clr", err_count, 0);
        check("t4_clr2", err_count2, 0);

        // 5: backpressure, overrun, accept with simultaneous new event
        out_ready = 1'b0;
        hold(8'hFF, 6);
        hold(8'hB0, 6);
        check("t5_valid3", out_valid, 1);
        check("t5_value3", out_value, 3);
        check("t5_ovr0", overrun, 0);
        hold(8'hF8, 6);
        check("t5_hold3", out_value, 3);
        check("t5_ovr1", overrun, 1);
        exp_q.push_back({1'b0, 4'h3});
        seg_in = 8'h98;
        step(4);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("t5_valid9", out_valid, 1);
        check("t5_value9", out_value, 9);
        check("t5_drain3", exp_q.size(), 0);
        exp_q.push_back({1'b0, 4'h9});
        out_ready = 1'b1;
        step(2);
        check("t5_clear", out_valid, 0);

        // 6: async reset mid-settle and mid-handshake
        hold(8'hFF, 6);
        seg_in = 8'hC0;
        step(3);
        #2 reset_n = 1'b0;
        #1;
        check("t6_state", state_dbg, 0);
        check("t6_ovr", overrun, 0);
        seg_in = 8'hFF;
        step(2);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("t6_noreplay_a", out_valid, 0);
        end
        out_ready = 1'b0;
        hold(8'hC0, 6);
        check("t6_valid", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_value", {out_dp, out_value}, 0);
        seg_in = 8'hFF;
        step(2);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("t6_noreplay_b", out_valid, 0);
        end
        exp_q.push_back({1'b0, 4'h2});
        hold(8'hA4, 8);
        check("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
